// File: rtl/lsu_mem_controller_pkg.sv
// Shared funct3 codes, FSM state encoding and request legality decode for the load/store sequencer.
// No storage, no latency, no flow control.
package lsu_mem_controller_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP,
    S_ERR
  } state_t;

  // Illegal funct3, unsigned stores, and misaligned H/W accesses; range is checked by the caller.
  function automatic logic req_illegal(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] lsb);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = write;
      F3_H:    bad = lsb[0];
      F3_HU:   bad = write | lsb[0];
      F3_W:    bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_controller_align.sv
// Load lane extract/extend and sub-word store merge into a fetched word.
// Purely combinational, no flow control.
module lsu_mem_controller_align
  import lsu_mem_controller_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    // Untouched bytes of the fetched word are kept as read.
    merge_data = word;
    if (funct3 == F3_B)
      merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H)
      merge_data[{lane[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/lsu_mem_controller.sv
// RV32I load/store sequencer onto a word-wide memory; loads/SW respond 2 cycles after accept, SB/SH 3, errors 1.
// req_ready only in IDLE, so one request is in flight at a time.
module lsu_mem_controller
  import lsu_mem_controller_pkg::*;
#(
  parameter int MEM_BYTES   = 256,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] merge_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        req_err;
  logic        is_sw;

  assign req_err = req_illegal(req_write, req_funct3, req_addr[1:0]) |
                   (CHECK_RANGE && (req_addr >= 32'(MEM_BYTES)));
  assign is_sw   = write_q && (funct3_q == F3_W);

  lsu_mem_controller_align u_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .word       (mem_rdata),
    .wdata      (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
            state    <= req_err ? S_ERR : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!write_q) begin
            rdata_q <= load_data;
            state   <= S_RESP;
          end else if (is_sw) begin
            state   <= S_RESP;
          end else begin
            merge_q <= merge_data;
            state   <= S_WRITE;
          end
        end
        S_WRITE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Everything the memory and core see is decoded from registered state only.
  always_comb begin
    req_ready  = (state == S_IDLE) && !reset;
    resp_valid = (state == S_RESP) || (state == S_ERR);
    resp_err   = (state == S_ERR);
    resp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
    mem_read   = (state == S_ACCESS) && !is_sw;
    mem_write  = ((state == S_ACCESS) && is_sw) || (state == S_WRITE);
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = 32'h0;
    if (state == S_WRITE)
      mem_wdata = merge_q;
    else if ((state == S_ACCESS) && is_sw)
      mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Directed bench for lsu_mem_controller with a 64-word behavioural data memory.
module tb_lsu_mem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_dat = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_dat;
    else if (mem_write)
      mem[mem_addr[7:2]] <= mem_wdata;
  end

  lsu_mem_controller #(.MEM_BYTES(256), .CHECK_RANGE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic poke(input int idx, input logic [31:0] dat);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 6'(idx);
    poke_dat = dat;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  // Issues one request from IDLE and observes it; cycle 1 is the cycle after the accept edge.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output int nrd, output int nwr, output int rdc,
                        output int wrc, output int both);
    lat = -1; rd = 32'hx; er = 1'bx; nrd = 0; nwr = 0; rdc = -1; wrc = -1; both = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_read) begin nrd++; if (rdc < 0) rdc = c; end
      if (mem_write) begin nwr++; if (wrc < 0) wrc = c; end
      if (mem_read && mem_write) both++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    tests++;
    if ({resp_rdata, mem_wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {resp_rdata, mem_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_sw_lw;
    int lat, nrd, nwr, rdc, wrc, both;
    logic [31:0] rd;
    logic er;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr, rdc, wrc, both);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=0", lat, er, rd);
    end
    tests++;
    if (nwr !== 1 || nrd !== 0 || wrc !== 1) begin
      fails++;
      $display("FAIL sw_strobes: got wr=%0d rd=%0d wrcyc=%0d expected 1 0 1", nwr, nrd, wrc);
    end
    @(negedge clk);
    tests++;
    if (mem[4] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, nrd, nwr, rdc, wrc, both);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || nrd !== 1 || nwr !== 0) begin
      fails++;
      $display("FAIL lw_10: got lat=%0d err=%b rdata=%h rd=%0d wr=%0d expected 2 0 deadbeef 1 0",
               lat, er, rd, nrd, nwr);
    end
  endtask

  task automatic test_sub_store;
    int lat, nrd, nwr, rdc, wrc, both;
    logic [31:0] rd;
    logic er;
    poke(4, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h11, 32'h000000A5, lat, rd, er, nrd, nwr, rdc, wrc, both);
    tests++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL sb_resp: got lat=%0d err=%b rdata=%h expected 3 0 0", lat, er, rd);
    end
    tests++;
    if (rdc !== 1 || wrc !== 2 || nrd !== 1 || nwr !== 1 || both !== 0) begin
      fails++;
      $display("FAIL sb_strobes: got rdcyc=%0d wrcyc=%0d rd=%0d wr=%0d both=%0d expected 1 2 1 1 0",
               rdc, wrc, nrd, nwr, both);
    end
    @(negedge clk);
    tests++;
    if (mem[4] !== 32'h1122A544) begin
      fails++;
      $display("FAIL sb_merge: got %h expected 1122a544", mem[4]);
    end
    do_req(1'b1, 3'b001, 32'h12, 32'h1234BEEF, lat, rd, er, nrd, nwr, rdc, wrc, both);
    @(negedge clk);
    tests++;
    if (lat !== 3 || mem[4] !== 32'hBEEFA544) begin
      fails++;
      $display("FAIL sh_merge: got lat=%0d mem=%h expected 3 beefa544", lat, mem[4]);
    end
  endtask

  task automatic test_loads;
    int lat, nrd, nwr, rdc, wrc, both;
    logic [31:0] rd;
    logic er;
    logic [2:0]  f3 [6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] ad [6]  = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h21, 32'hFC};
    logic [31:0] ex [6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000,
                             32'hFFFFFFFF, 32'h0BADF00D};
    poke(8, 32'h8000FF80);
    poke(63, 32'h0BADF00D);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, rdc, wrc, both);
      tests++;
      if (lat !== 2 || er !== 1'b0 || rd !== ex[i]) begin
        fails++;
        $display("FAIL load_%0d: got lat=%0d err=%b rdata=%h expected 2 0 %h", i, lat, er, rd, ex[i]);
      end
    end
  endtask

  task automatic test_errors;
    int lat, nrd, nwr, rdc, wrc, both;
    logic [31:0] rd;
    logic er;
    logic        w  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
    logic [31:0] ad [5] = '{32'h13, 32'h05, 32'h00, 32'h100, 32'h08};
    for (int i = 0; i < 5; i++) begin
      do_req(w[i], f3[i], ad[i], 32'hFFFFFFFF, lat, rd, er, nrd, nwr, rdc, wrc, both);
      tests++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
        fails++;
        $display("FAIL err_%0d: got lat=%0d err=%b rdata=%h rd=%0d wr=%0d expected 1 1 0 0 0",
                 i, lat, er, rd, nrd, nwr);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen_wr = 0;
    int seen_rv = 0;
    poke(5, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) seen_wr++;
      if (resp_valid) seen_rv++;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_write) seen_wr++;
      if (resp_valid) seen_rv++;
    end
    tests++;
    if (seen_wr !== 0 || seen_rv !== 0) begin
      fails++;
      $display("FAIL rst_mid_strobes: got wr=%0d resp=%0d expected 0 0", seen_wr, seen_rv);
    end
    tests++;
    if (mem[5] !== 32'hCAFEF00D || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_state: got mem=%h ready=%b expected cafef00d 1", mem[5], req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic        rdy [6];
    logic        rv  [6];
    logic [31:0] rdt [6];
    poke(4, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rdy[c] = req_ready; rv[c] = resp_valid; rdt[c] = resp_rdata;
      if (c == 1) req_addr = 32'h20;
    end
    req_valid = 1'b0;
    tests++;
    if ({rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]} !== 5'b00100) begin
      fails++;
      $display("FAIL b2b_ready: got %b expected 00100", {rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]});
    end
    tests++;
    if (rv[2] !== 1'b1 || rdt[2] !== 32'hDEADBEEF || rv[3] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got rv=%b rdata=%h rv3=%b expected 1 deadbeef 0", rv[2], rdt[2], rv[3]);
    end
    tests++;
    if (rv[5] !== 1'b1 || rdt[5] !== 32'h8000FF80) begin
      fails++;
      $display("FAIL b2b_second: got rv=%b rdata=%h expected 1 8000ff80", rv[5], rdt[5]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sub_store();
    test_loads();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
